qdi_rx_word_sched: RTL

Clocked scheduler that shares one synchronous word assembler between N_CH e1of2 dual-rail QDI output channels. It performs the 4-phase handshake on each channel's enable (Le), arbitrates round-robin between channels presenting data, and collects W bits from the granted channel into one word. The assembled word is delivered to the synchronous (verilog) side with a valid/ready handshake. It sits at the QDI-to-binary boundary wherever several asynchronous producers feed one clocked consumer.

---
 rtl/qdi_rx_word_sched_if.sv | 27 ++
 rtl/qdi_rx_word_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/qdi_rx_word_sched_if.sv
// Bundle between the QDI rail side / word consumer and the shared word assembler.
// master = the scheduler, slave = the environment (QDI channels plus consumer).
interface qdi_rx_word_sched_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);
  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [2*N_CH-1:0] L;
  logic [N_CH-1:0]   Le;
  logic [W-1:0]      dout;
  logic [ChW-1:0]    dch;
  logic              valid;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    input  L, ready,
    output Le, dout, dch, valid, err, busy
  );

  modport slave (
    output L, ready,
    input  Le, dout, dch, valid, err, busy
  );
endinterface

// File: rtl/qdi_rx_word_sched.sv
// Shares one word assembler between N_CH dual-rail QDI channels: round-robin grant,
// 4-phase Le handshake per bit, valid/ready delivery of the finished word.
module qdi_rx_word_sched #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned SYNC = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  qdi_rx_word_sched_if.master        bus,
  inout  wire                        VDD,
  inout  wire                        GND
);
  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StCapture, StAck, StEmit} state_e;

  state_e              state_q, state_d;
  logic [2*N_CH-1:0]   sync_q [SYNC];
  logic [2*N_CH-1:0]   prev_q;
  logic [2*N_CH-1:0]   s;
  logic [N_CH-1:0]     req;
  logic [N_CH-1:0]     le_q, le_d;
  logic [W-1:0]        word_q, word_d;
  logic [ChW-1:0]      gnt_q, gnt_d, ptr_q, ptr_d;
  logic [ChW-1:0]      gnt_sel, ptr_next;
  logic                gnt_found;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          s_g, p_g;

  // Supply pins carry no logic; fold them so they are consumed.
  wire unused_supply;
  assign unused_supply = VDD ^ GND;

  assign s = sync_q[SYNC-1];

  always_comb begin
    req = '0;
    s_g = 2'b00;
    p_g = 2'b00;
    for (int c = 0; c < int'(N_CH); c++) begin
      req[c] = |s[2*c +: 2];
      if (gnt_q == ChW'(c)) begin
        s_g = s[2*c +: 2];
        p_g = prev_q[2*c +: 2];
      end
    end
  end

  // First requester at or after the pointer, wrapping modulo N_CH.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    ptr_next  = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (!gnt_found && req[c] && ((int'(ptr_q) + k) % int'(N_CH)) == c) begin
          gnt_found = 1'b1;
          gnt_sel   = ChW'(c);
          ptr_next  = ChW'((c + 1) % int'(N_CH));
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    le_d    = le_q;
    word_d  = word_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          gnt_d   = gnt_sel;
          ptr_d   = ptr_next;
          state_d = StCapture;
        end
      end
      StCapture: begin
        // Two equal non-neutral samples in a row accept the bit; 11 is taken as 0.
        if (s_g != 2'b00 && s_g == p_g) begin
          for (int i = 0; i < int'(W); i++) begin
            if (cnt_q == CntW'(i)) word_d[i] = (s_g == 2'b10);
          end
          err_d = (s_g == 2'b11);
          for (int c = 0; c < int'(N_CH); c++) begin
            if (gnt_q == ChW'(c)) le_d[c] = 1'b0;
          end
          state_d = StAck;
        end
      end
      StAck: begin
        if (s_g == 2'b00 && p_g == 2'b00) begin
          for (int c = 0; c < int'(N_CH); c++) begin
            if (gnt_q == ChW'(c)) le_d[c] = 1'b1;
          end
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == CntW'(W)) ? StEmit : StCapture;
        end
      end
      StEmit: begin
        if (bus.ready) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(SYNC); i++) sync_q[i] <= '0;
      prev_q  <= '0;
      state_q <= StIdle;
      le_q    <= '1;
      word_q  <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sync_q[0] <= bus.L;
      for (int i = 1; i < int'(SYNC); i++) sync_q[i] <= sync_q[i-1];
      prev_q  <= s;
      state_q <= state_d;
      le_q    <= le_d;
      word_q  <= word_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.Le    = le_q;
  assign bus.dout  = word_q;
  assign bus.dch   = gnt_q;
  assign bus.valid = (state_q == StEmit);
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != StIdle);
endmodule
